conv_window_reader: RTL and testbench
=====================================

Name: conv_window_reader

Overview:
- Read-side master for the 5-port convolution data buffer. Drives all K read-address ports each cycle and fetches one K-tall image column per cycle.
- The buffer returns data combinationally in the same cycle. The column is shifted into a KxK window register.
- Raster-scans an IMG_W x IMG_H feature map stored row-major at base_addr and streams every valid KxK window (stride 1, no padding) to the conv kernel over valid/ready.

Parameters:
- WIDTH, 16, data word width
- ADDR_WIDTH, 32, address width (project-wide 32-bit)
- K, 5, kernel size = read port count (OUT_PORT_NUM of buffer)
- IMG_W, 28, map width in words
- IMG_H, 28, map height in words
- DEPTH, 1024, buffer depth (used by optional check)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse, begin scan (IDLE only)
- base_addr  in  ADDR_WIDTH  map base address, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, scan complete
- rd_addr_NP  out  K*ADDR_WIDTH  port i = slice [(i+1)*ADDR_WIDTH-1:i*ADDR_WIDTH], row offset i
- rd_data_NP  in  K*WIDTH  port i data, same-cycle response
- win_data  out  K*K*WIDTH  element (r,c) at [(r*K+c+1)*WIDTH-1:(r*K+c)*WIDTH], c=0 leftmost
- win_valid  out  1  window valid
- win_ready  in  1  consumer accepts window
- addr_err  out  1  sticky address-range error (optional feature)

Behaviour:
- Reset: state=IDLE. busy, done, win_valid and addr_err are 0. win_data, rd_addr_NP and the counters row/col/row_base are 0.
- States:
  - IDLE: start → RUN. Latch row_base=base_addr, row=0, col=0.
  - RUN: fetch while fetch_en.
  - DRAIN: wait for the last window handshake.
  - Then return to IDLE with done=1 for one cycle.
- start is ignored outside IDLE.
- rd_addr port i = row_base + i*IMG_W + col. Computed combinationally from registers. i*IMG_W is a constant; no run-time multiplier. Wraps modulo 2^ADDR_WIDTH.
- fetch_en = (state==RUN) && (!win_valid || win_ready).
- On a fetch cycle:
  - Every row of the window shifts left one column; column K-1 takes rd_data_NP port r.
  - win_valid <= (col >= K-1).
  - col++.
- Not fetching and win_valid && win_ready: win_valid <= 0.
- win_valid && !win_ready: window, addresses and counters hold.
- End of row (fetch with col==IMG_W-1): col=0, row++, row_base += IMG_W. The next K-1 fetches refill the window with no output.
- End of scan (end-of-row fetch with row==IMG_H-K): → DRAIN. On the win_valid && win_ready handshake → IDLE, done=1 next cycle, busy=0 the same cycle as done.
- Windows per scan = (IMG_W-K+1)*(IMG_H-K+1), emitted in raster order.
- Latency with win_ready=1:
  - start at cycle 0, first fetch at cycle 1.
  - First win_valid at cycle K+1.
  - Then one window per cycle within a row.
  - Bubble of K-1 cycles at each row change.
- Async reset mid-scan aborts immediately to reset values. No done.
- Elaboration requires IMG_W>=K and IMG_H>=K.

Optional Feature:
- Macro: CONV_READER_ADDR_CHECK_EN.
- Defined: on any fetch cycle where any issued address >= DEPTH, addr_err is set. It stays set until rst_n or the next accepted start. The scan continues unaffected.
- Undefined: addr_err is tied to 0 and no compare logic is built.

Decomposition:
- Shared package conv_pkg holds:
  - ADDR_WIDTH=32, WIDTH=16, K=5 constants
  - state encoding typedef (IDLE, RUN, DRAIN)
  - window-element index helper constant/function (r*K+c)
- One natural sub-module, conv_window_shreg: KxK shift register with shift enable, parallel column load and flat win_data output.
- Address/counter FSM stays in the top.

Test Plan:
- Setup for all tests: IMG_W=8, IMG_H=6, K=5, mem[a]=a, base=0, win_ready=1, start at cycle 0.
  - Window 0 valid at cycle 6, element (r,c)=8r+c.
  - Exactly 8 windows.
  - Last window element (0,0)=11.
  - done pulse exactly one cycle after the final handshake.
- base=100: window 0 element (4,4)=136. rd_addr port 2 at cycle 1 = 116.
- Backpressure: win_ready low 3 cycles at window 2. win_valid, win_data and rd_addr_NP stay stable. Window sequence unchanged and no duplicates.
- start pulsed again while busy: ignored. Window count stays 8, single done.
- rst_n asserted mid-row 1: all outputs 0 asynchronously. A fresh start then repeats the test-1 sequence exactly.
- With CONV_READER_ADDR_CHECK_EN and DEPTH=40: addr_err rises on the first fetch whose port-4 address >= 40. Cleared by the next start with base=0, DEPTH=1024.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, state encoding and window indexing for the convolution window reader.
package conv_pkg;

    localparam int CONV_ADDR_WIDTH = 32;
    localparam int CONV_WIDTH      = 16;
    localparam int CONV_K          = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Flat position of window element (r,c); c=0 is the leftmost (oldest) column.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/conv_window_shreg.sv
// KxK window register: each enabled cycle shifts every row left and loads a new rightmost column.
module conv_window_shreg
    import conv_pkg::*;
#(
    parameter int WIDTH = CONV_WIDTH,
    parameter int K     = CONV_K
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   shift_en,
    input  logic [K*WIDTH-1:0]     col_in,
    output logic [K*K*WIDTH-1:0]   win_data
);

    logic [WIDTH-1:0] win_q [K*K];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K*K; i++) begin
                win_q[i] <= '0;
            end
        end else if (shift_en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    if (c == K-1) begin
                        win_q[win_idx(r, c, K)] <= col_in[r*WIDTH +: WIDTH];
                    end else begin
                        win_q[win_idx(r, c, K)] <= win_q[win_idx(r, c + 1, K)];
                    end
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < K*K; i++) begin
            win_data[i*WIDTH +: WIDTH] = win_q[i];
        end
    end

endmodule

// File: rtl/conv_window_reader.sv
// Raster-scan read master for the K-port conv buffer, streaming every KxK window over valid/ready.
// Optional address-range error flag enabled by defining CONV_READER_ADDR_CHECK_EN.
module conv_window_reader
    import conv_pkg::*;
#(
    parameter int WIDTH      = CONV_WIDTH,
    parameter int ADDR_WIDTH = CONV_ADDR_WIDTH,
    parameter int K          = CONV_K,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int DEPTH      = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic                      busy,
    output logic                      done,
    output logic [K*ADDR_WIDTH-1:0]   rd_addr_NP,
    input  logic [K*WIDTH-1:0]        rd_data_NP,
    output logic [K*K*WIDTH-1:0]      win_data,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic                      addr_err
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    if (IMG_W < K || IMG_H < K || DEPTH < 1) begin : g_bad_cfg
        $error("conv_window_reader: map must be at least KxK and DEPTH positive");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_base_q;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic                  win_valid_q;
    logic                  done_q;
    logic                  fetch_en;
    logic                  start_acc;
    logic                  end_of_row;
    logic                  last_row;

    assign start_acc  = (state_q == IDLE) && start;
    assign end_of_row = (col_q == CW'(IMG_W - 1));
    assign last_row   = (row_q == RW'(IMG_H - K));

    always_comb begin
        state_d  = state_q;
        fetch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                fetch_en = !win_valid_q || win_ready;
                if (fetch_en && end_of_row && last_row) state_d = DRAIN;
            end
            DRAIN: begin
                if (win_valid_q && win_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) && win_valid_q && win_ready;
            if (start_acc) begin
                row_base_q <= base_addr;
                col_q      <= '0;
                row_q      <= '0;
            end else if (fetch_en) begin
                if (end_of_row) begin
                    col_q      <= '0;
                    row_q      <= row_q + 1'b1;
                    row_base_q <= row_base_q + ADDR_WIDTH'(IMG_W);
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            // A window completes once K columns of the current row have been shifted in.
            if (fetch_en) begin
                win_valid_q <= (col_q >= CW'(K - 1));
            end else if (win_valid_q && win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    // Addresses are parked at zero while idle so the buffer sees a quiet bus.
    always_comb begin
        rd_addr_NP = '0;
        if (state_q != IDLE) begin
            for (int i = 0; i < K; i++) begin
                rd_addr_NP[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    row_base_q + ADDR_WIDTH'(i * IMG_W) + ADDR_WIDTH'(col_q);
            end
        end
    end

    conv_window_shreg #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (fetch_en),
        .col_in   (rd_data_NP),
        .win_data (win_data)
    );

`ifdef CONV_READER_ADDR_CHECK_EN
    logic addr_oob;
    logic addr_err_q;

    always_comb begin
        addr_oob = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (rd_addr_NP[i*ADDR_WIDTH +: ADDR_WIDTH] >= ADDR_WIDTH'(DEPTH)) addr_oob = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     addr_err_q <= 1'b0;
        else if (start_acc)             addr_err_q <= 1'b0;
        else if (fetch_en && addr_oob)  addr_err_q <= 1'b1;
    end

    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader on an 8x6 map with K=5 and mem[a]=a.
module tb_conv_window_reader;

    localparam int W  = 16;
    localparam int AW = 32;
    localparam int KK = 5;
    localparam int IW = 8;
    localparam int IH = 6;
`ifdef CONV_READER_ADDR_CHECK_EN
    localparam int DEP        = 40;
    localparam int ERR_B0     = 10;
    localparam int ERR_B100   = 2;
    localparam int ERR_B0_STL = 13;
`else
    localparam int DEP        = 1024;
    localparam int ERR_B0     = 0;
    localparam int ERR_B100   = 0;
    localparam int ERR_B0_STL = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic                 busy;
    logic                 done;
    logic [KK*AW-1:0]     rd_addr_NP;
    logic [KK*W-1:0]      rd_data_NP;
    logic [KK*KK*W-1:0]   win_data;
    logic                 win_valid;
    logic                 win_ready;
    logic                 addr_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        rd_data_NP = '0;
        for (int i = 0; i < KK; i++) begin
            rd_data_NP[i*W +: W] = rd_addr_NP[i*AW +: W];
        end
    end

    conv_window_reader #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .K          (KK),
        .IMG_W      (IW),
        .IMG_H      (IH),
        .DEPTH      (DEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .rd_addr_NP (rd_addr_NP),
        .rd_data_NP (rd_data_NP),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .addr_err   (addr_err)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KK*KK*W-1:0] exp_win(input logic [AW-1:0] base, input int n);
        logic [KK*KK*W-1:0] v;
        logic [AW-1:0]      a;
        int tr, tc;
        v  = '0;
        tr = n / (IW - KK + 1);
        tc = n % (IW - KK + 1);
        for (int r = 0; r < KK; r++) begin
            for (int c = 0; c < KK; c++) begin
                a = base + AW'((tr + r) * IW + tc + c);
                v[(r*KK + c)*W +: W] = a[W-1:0];
            end
        end
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     busy,       0);
        check({tag, "_done"},     done,       0);
        check({tag, "_valid"},    win_valid,  0);
        check({tag, "_win"},      win_data,   0);
        check({tag, "_rd_addr"},  rd_addr_NP, 0);
        check({tag, "_addr_err"}, addr_err,   0);
    endtask

    // One full scan; returns after done plus a few idle cycles, or after a cycle budget.
    task automatic scan(input logic [AW-1:0] base, input int stall_at, input int stall_len,
                        input bit restart, input int err_cyc);
        int cyc, n, stalls, done_cnt, done_cyc, last_hs;
        logic [KK*KK*W-1:0] held_win;
        logic [KK*AW-1:0]   held_addr;
        @(posedge clk); #1;
        base_addr = base;
        start     = 1'b1;
        win_ready = 1'b1;
        cyc = 0; n = 0; stalls = 0; done_cnt = 0; done_cyc = 0; last_hs = -1;
        held_win = '0; held_addr = '0;
        while (cyc < 120 && !(done_cnt > 0 && cyc >= done_cyc + 3)) begin
            @(posedge clk); #1;
            cyc++;
            start     = restart && (cyc == 3);
            win_ready = !(n == stall_at && stalls < stall_len);
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_c1",      busy, 1);
                check("rd_addr2_c1",  rd_addr_NP[2*AW +: AW], base + 32'd16);
                check("addr_err_c1",  addr_err, 0);
            end
            if (err_cyc > 0 && cyc == err_cyc - 1) check("addr_err_before", addr_err, 0);
            if (err_cyc > 0 && cyc == err_cyc)     check("addr_err_rise",   addr_err, 1);
            if (win_valid && !win_ready) begin
                if (stalls == 0) begin
                    held_win  = win_data;
                    held_addr = rd_addr_NP;
                end else begin
                    check("stall_win",  win_data,   held_win);
                    check("stall_addr", rd_addr_NP, held_addr);
                end
                stalls++;
            end
            if (win_valid && win_ready) begin
                if (stall_at < 0) check("win_cycle", cyc, 6 + n % 4 + (n / 4) * 8);
                check("win_data", win_data, exp_win(base, n));
                if (n == 0) check("win0_e44", win_data[24*W +: W], base[W-1:0] + 16'd36);
                if (n == 7) check("win7_e00", win_data[W-1:0],     base[W-1:0] + 16'd11);
                n++;
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    check("done_after_hs", cyc, last_hs + 1);
                    check("busy_at_done",  busy, 0);
                    check("win_count",     n, 8);
                end
            end
        end
        start     = 1'b0;
        win_ready = 1'b1;
        check("done_count",  done_cnt, 1);
        check("stall_count", stalls, (stall_at >= 0) ? stall_len : 0);
        check("addr_err_end", addr_err, (err_cyc > 0) ? 1 : 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        win_ready = 1'b1;
        base_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        scan(32'd0,   -1, 0, 1'b0, ERR_B0);
        scan(32'd100, -1, 0, 1'b0, ERR_B100);
        scan(32'd0,    2, 3, 1'b0, ERR_B0_STL);
        scan(32'd0,   -1, 0, 1'b1, ERR_B0);

        // Abort mid-row 1 while a window is being presented.
        @(posedge clk); #1;
        base_addr = '0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("pre_abort_valid", win_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        #3;
        rst_n = 1'b1;

        scan(32'd0, -1, 0, 1'b0, ERR_B0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
